// File: rtl/count_capture_fifo_if.sv
// Capture-FIFO bus: counter snapshot input, trigger controls,
// valid/ready read port and status flags.
interface count_capture_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] counter_state;
  logic             cnt_valid;
  logic             cap_trig;
  logic             cap_en;
  logic             flag_clr;
`ifdef CAPTURE_EDGE_SEL_EN
  logic             edge_sel;
`endif
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             overrun;
  logic             miss;

  modport master (
    output counter_state,
    output cnt_valid,
    output cap_trig,
    output cap_en,
    output flag_clr,
`ifdef CAPTURE_EDGE_SEL_EN
    output edge_sel,
`endif
    output rd_ready,
    input  rd_valid,
    input  rd_data,
    input  level,
    input  full,
    input  empty,
    input  overrun,
    input  miss
  );

  modport slave (
    input  counter_state,
    input  cnt_valid,
    input  cap_trig,
    input  cap_en,
    input  flag_clr,
`ifdef CAPTURE_EDGE_SEL_EN
    input  edge_sel,
`endif
    input  rd_ready,
    output rd_valid,
    output rd_data,
    output level,
    output full,
    output empty,
    output overrun,
    output miss
  );
endinterface

// File: rtl/count_capture_fifo.sv
// Counter snapshot FIFO (FWFT). Define CAPTURE_EDGE_SEL_EN
// to add bus.edge_sel (0 = rising, 1 = falling trigger edge).
module count_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  count_capture_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_trig_q;
  logic             r_arm;
  logic             r_overrun;
  logic             r_miss;

  logic w_rise;
  logic w_fall;
  logic w_sel;
  logic w_edge;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_ovr_set;
  logic w_miss_set;

  assign w_rise = bus.cap_trig & ~r_trig_q;
  assign w_fall = ~bus.cap_trig & r_trig_q;

`ifdef CAPTURE_EDGE_SEL_EN
  assign w_sel = bus.edge_sel ? w_fall : w_rise;
`else
  assign w_sel = w_rise;
`endif

  assign w_edge  = r_arm & bus.cap_en & w_sel;
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = ~w_empty & bus.rd_ready;

  // A full FIFO still takes the push when a pop frees a slot.
  assign w_push = w_edge & bus.cnt_valid
                & (~w_full | w_pop);
  assign w_ovr_set = w_edge & bus.cnt_valid
                   & w_full & ~w_pop;
  assign w_miss_set = w_edge & ~bus.cnt_valid;

  always_ff @(posedge clk) begin
    r_trig_q <= bus.cap_trig;
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_arm     <= 1'b0;
      r_overrun <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.counter_state;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case (1'b1)
        (w_push & ~w_pop): r_level <= r_level + LW'(1);
        (w_pop & ~w_push): r_level <= r_level - LW'(1);
        default:           r_level <= r_level;
      endcase
      // Clear wins over a same-cycle set.
      if (bus.flag_clr) begin
        r_overrun <= 1'b0;
        r_miss    <= 1'b0;
      end else begin
        if (w_ovr_set)  r_overrun <= 1'b1;
        if (w_miss_set) r_miss    <= 1'b1;
      end
    end
  end

  assign bus.rd_valid = ~w_empty;
  assign bus.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.level    = r_level;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.overrun  = r_overrun;
  assign bus.miss     = r_miss;
endmodule
